// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider: 32-bit sequential restoring divider, signed or unsigned operands.
//   One division per start request; 32 shift-subtract iterations, one per cycle,
//   then results are presented with a one-cycle div_end pulse.
//
// Ports
//   clk        in   clock, rising edge
//   resetn     in   asynchronous active-low reset
//   div_begin  in   start request (accepted only in IDLE)
//   div_signed in   1 = two's-complement operands, 0 = unsigned
//   div_op1    in   [31:0] dividend
//   div_op2    in   [31:0] divisor
//   busy       out  division in progress
//   div_end    out  one-cycle pulse, quotient/remainder valid
//   quotient   out  [31:0] quotient, held until the next completion
//   remainder  out  [31:0] remainder, held until the next completion
//   div_zero   out  divisor was zero (only with DIV_ZERO_FLAG_EN defined)
//
// Configuration macro: DIV_ZERO_FLAG_EN adds the div_zero flag output.
// -----------------------------------------------------------------------------
module divider #(
  localparam int unsigned W  = 32,
  localparam int unsigned CW = 5
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         div_begin,
  input  logic         div_signed,
  input  logic [W-1:0] div_op1,
  input  logic [W-1:0] div_op2,
  output logic         busy,
  output logic         div_end,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic         div_zero
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  pr;         // {partial remainder, dividend/quotient bits}
  logic [W-1:0]    dvsr;       // divisor magnitude
  logic [W-1:0]    op1_q;      // raw dividend, returned as remainder on /0
  logic            neg_q;
  logic            neg_r;
  logic            dvsr_zero;

  logic [W:0]      hi;
  logic            take;
  logic [W-1:0]    sub;
  logic [2*W-1:0]  pr_nxt;
  logic [W-1:0]    q_fix;
  logic [W-1:0]    r_fix;
  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (div_begin) state_nxt = CALC;
      CALC:    if (cnt == LAST_ITER) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring iteration plus sign fix-up of its result
  always_comb begin
    // Shifted partial remainder can reach 33 bits; the difference, when kept,
    // is always below the divisor so its low 32 bits are exact.
    hi     = pr[2*W-1:W-1];
    take   = (hi >= {1'b0, dvsr});
    sub    = hi[W-1:0] - dvsr;
    pr_nxt = {(take ? sub : hi[W-1:0]), pr[W-2:0], take};

    q_fix  = neg_q ? (W'(0) - pr_nxt[W-1:0])   : pr_nxt[W-1:0];
    r_fix  = neg_r ? (W'(0) - pr_nxt[2*W-1:W]) : pr_nxt[2*W-1:W];
    if (dvsr_zero) begin
      q_fix = '1;
      r_fix = op1_q;
    end

    // Magnitudes; 0x80000000 maps to itself, read as unsigned
    a_mag = (div_signed && div_op1[W-1]) ? (W'(0) - div_op1) : div_op1;
    b_mag = (div_signed && div_op2[W-1]) ? (W'(0) - div_op2) : div_op2;
  end

  // State register, datapath and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      pr        <= '0;
      dvsr      <= '0;
      op1_q     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dvsr_zero <= 1'b0;
      busy      <= 1'b0;
      div_end   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_FLAG_EN
      div_zero  <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt == CALC);
      div_end <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (div_begin) begin
            pr        <= {W'(0), a_mag};
            dvsr      <= b_mag;
            op1_q     <= div_op1;
            neg_q     <= div_signed & (div_op1[W-1] ^ div_op2[W-1]);
            neg_r     <= div_signed & div_op1[W-1];
            dvsr_zero <= (div_op2 == W'(0));
            cnt       <= '0;
          end
        end
        CALC: begin
          pr  <= pr_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_ITER) begin
            quotient  <= q_fix;
            remainder <= r_fix;
`ifdef DIV_ZERO_FLAG_EN
            div_zero  <= dvsr_zero;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider: directed and random self-checking bench for divider.
// -----------------------------------------------------------------------------
module tb_divider;

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_begin;
  logic        div_signed;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic        busy;
  logic        div_end;
  logic [31:0] quotient;
  logic [31:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_zero;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  divider dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_begin  (div_begin),
    .div_signed (div_signed),
    .div_op1    (div_op1),
    .div_op2    (div_op2),
    .busy       (busy),
    .div_end    (div_end),
    .quotient   (quotient),
    .remainder  (remainder)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero   (div_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {quotient, remainder}
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    int sa, sb;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (!s) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
    sa = int'(a);
    sb = int'(b);
    return {32'(sa / sb), 32'(sa % sb)};
  endfunction

  // Present operands with div_begin for exactly one rising edge
  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    div_op1 = a; div_op2 = b; div_signed = s; div_begin = 1'b1;
    @(negedge clk);
    div_begin = 1'b0;
  endtask

  // Called in cycle 1 after the accepting edge; returns cycle of div_end
  task automatic wait_end(output int n, output int nbusy);
    n = 1;
    nbusy = 0;
    while (!div_end && n < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] eq, input logic [31:0] er);
    int n, nb;
    start(a, b, s);
    wait_end(n, nb);
    check({tag, " latency"}, 64'(n), 64'd33);
    check({tag, " busy cycles"}, 64'(nb), 64'd32);
    check({tag, " busy in done"}, 64'(busy), 64'd0);
    check({tag, " quotient"}, 64'(quotient), 64'(eq));
    check({tag, " remainder"}, 64'(remainder), 64'(er));
`ifdef DIV_ZERO_FLAG_EN
    check({tag, " div_zero"}, 64'(div_zero), 64'(b == 32'd0));
`endif
  endtask

  initial begin
    int n, nb, ends;
    logic [31:0] a, b;
    logic s;

    resetn = 1'b0; div_begin = 1'b0; div_signed = 1'b0;
    div_op1 = '0; div_op2 = '0;
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset div_end", 64'(div_end), 64'd0);
    check("reset results", {quotient, remainder}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed vectors with hand-computed results
    do_vec("u 100/7",       32'd100,         32'd7,           1'b0, 32'd14,          32'd2);
    do_vec("s -7/2",        32'hFFFF_FFF9,   32'd2,           1'b1, 32'hFFFF_FFFD,   32'hFFFF_FFFF);
    do_vec("s 7/-2",        32'd7,           32'hFFFF_FFFE,   1'b1, 32'hFFFF_FFFD,   32'd1);
    do_vec("s min/-1",      32'h8000_0000,   32'hFFFF_FFFF,   1'b1, 32'h8000_0000,   32'd0);
    do_vec("u min/max",     32'h8000_0000,   32'hFFFF_FFFF,   1'b0, 32'd0,           32'h8000_0000);
    do_vec("u x/0",         32'h1234_5678,   32'd0,           1'b0, 32'hFFFF_FFFF,   32'h1234_5678);
    do_vec("s -5/0",        32'hFFFF_FFFB,   32'd0,           1'b1, 32'hFFFF_FFFF,   32'hFFFF_FFFB);
    do_vec("u 0/9",         32'd0,           32'd9,           1'b0, 32'd0,           32'd0);
    do_vec("u max/1",       32'hFFFF_FFFF,   32'd1,           1'b0, 32'hFFFF_FFFF,   32'd0);
    do_vec("s -100/-7",     32'hFFFF_FF9C,   32'hFFFF_FFF9,   1'b1, 32'd14,          32'hFFFF_FFFE);

    // Start requests during CALC and DONE must be ignored
    start(32'd100, 32'd7, 1'b0);
    n = 1;
    while (!div_end && n < 40) begin
      if (n == 10) begin
        div_op1 = 32'd50; div_op2 = 32'd5; div_begin = 1'b1;
      end else begin
        div_begin = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    check("busy-start latency", 64'(n), 64'd33);
    div_begin = 1'b1;
    @(negedge clk);
    div_begin = 1'b0;
    check("done-start busy", 64'(busy), 64'd0);
    ends = 0;
    for (int i = 0; i < 40; i++) begin
      if (div_end || busy) ends++;
      @(negedge clk);
    end
    check("done-start no restart", 64'(ends), 64'd0);
    check("busy-start results", {quotient, remainder}, {32'd14, 32'd2});

    // Reset in the middle of CALC
    start(32'd1000, 32'd3, 1'b0);
    repeat (14) @(negedge clk);
    check("pre-reset busy", 64'(busy), 64'd1);
    resetn = 1'b0;
    #1;
    check("mid reset busy", 64'(busy), 64'd0);
    check("mid reset div_end", 64'(div_end), 64'd0);
    check("mid reset results", {quotient, remainder}, 64'd0);
    ends = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_end) ends++;
    end
    check("mid reset no div_end", 64'(ends), 64'd0);
    resetn = 1'b1;
    do_vec("post-reset 9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

    // Random operands and modes against the reference model
    for (int k = 0; k < 1000; k++) begin
      a = $urandom;
      b = $urandom;
      case (k % 8)
        0: b = 32'd0;
        1: b = b >> $urandom_range(31, 0);
        2: a = a >> $urandom_range(31, 0);
        default: ;
      endcase
      s = 1'($urandom_range(1, 0));
      start(a, b, s);
      wait_end(n, nb);
      check("rand latency", 64'(n), 64'd33);
      check("rand result", {quotient, remainder}, model(a, b, s));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
